// File: rtl/dma_desc_scheduler.sv
// Round-robin DMA descriptor scheduler: latches enabled non-empty slots on go,
// hands them one at a time to a streamer and records per-slot completion status.
module dma_desc_scheduler #(
  parameter int NUM_DESC = 2,
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 32,
  localparam int ID_W    = $clog2(NUM_DESC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go_i,
  input  logic                       abort_i,
  input  logic [NUM_DESC-1:0]        desc_en_i,
  input  logic [NUM_DESC*ADDR_W-1:0] desc_src_i,
  input  logic [NUM_DESC*ADDR_W-1:0] desc_dst_i,
  input  logic [NUM_DESC*LEN_W-1:0]  desc_len_i,
  output logic                       str_valid_o,
  input  logic                       str_ready_i,
  output logic [ADDR_W-1:0]          str_src_o,
  output logic [ADDR_W-1:0]          str_dst_o,
  output logic [LEN_W-1:0]           str_len_o,
  output logic [ID_W-1:0]            str_id_o,
  input  logic                       str_done_i,
  input  logic                       str_err_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       aborted_o,
  output logic [NUM_DESC-1:0]        desc_done_o,
  output logic [NUM_DESC-1:0]        desc_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [NUM_DESC-1:0] pending_q;
  logic                abort_pend_q;
  logic                str_valid_q, busy_q, done_q, err_q, aborted_q;
  logic [ADDR_W-1:0]   str_src_q, str_dst_q;
  logic [LEN_W-1:0]    str_len_q;
  logic [ID_W-1:0]     str_id_q;
  logic [NUM_DESC-1:0] desc_done_q, desc_err_q;

  logic [NUM_DESC-1:0] go_pending_d, pending_clr_d;
  logic [ID_W-1:0]     sel_id_d, sel_hi_d, sel_lo_d, rr_next_d;
  logic                found_hi_d;

  always_comb begin
    go_pending_d = '0;
    for (int k = 0; k < NUM_DESC; k++)
      go_pending_d[k] = desc_en_i[k] && (desc_len_i[k*LEN_W +: LEN_W] != '0);
  end

  // Lowest pending slot at or above rr_ptr wins; otherwise wrap to the lowest pending slot.
  always_comb begin
    sel_hi_d   = '0;
    sel_lo_d   = '0;
    found_hi_d = 1'b0;
    for (int j = NUM_DESC - 1; j >= 0; j--) begin
      if (pending_q[j]) begin
        sel_lo_d = ID_W'(j);
        if (ID_W'(j) >= rr_ptr_q) begin
          sel_hi_d   = ID_W'(j);
          found_hi_d = 1'b1;
        end
      end
    end
    sel_id_d = found_hi_d ? sel_hi_d : sel_lo_d;
  end

  always_comb begin
    pending_clr_d           = pending_q;
    pending_clr_d[str_id_q] = 1'b0;
    rr_next_d = (str_id_q == ID_W'(NUM_DESC - 1)) ? '0 : str_id_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      pending_q    <= '0;
      abort_pend_q <= 1'b0;
      str_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      str_src_q    <= '0;
      str_dst_q    <= '0;
      str_len_q    <= '0;
      str_id_q     <= '0;
      desc_done_q  <= '0;
      desc_err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            pending_q    <= go_pending_d;
            abort_pend_q <= 1'b0;
            err_q        <= 1'b0;
            aborted_q    <= 1'b0;
            desc_done_q  <= '0;
            desc_err_q   <= '0;
            busy_q       <= 1'b1;
            state_q      <= (go_pending_d != '0) ? S_ARB : S_FIN;
          end
        end
        S_ARB: begin
          if (abort_i) begin
            aborted_q <= 1'b1;
            state_q   <= S_FIN;
          end else begin
            str_src_q   <= desc_src_i[sel_id_d*ADDR_W +: ADDR_W];
            str_dst_q   <= desc_dst_i[sel_id_d*ADDR_W +: ADDR_W];
            str_len_q   <= desc_len_i[sel_id_d*LEN_W +: LEN_W];
            str_id_q    <= sel_id_d;
            str_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort_i) begin
            abort_pend_q <= 1'b1;
            aborted_q    <= 1'b1;
          end
          if (str_ready_i) begin
            str_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort_i) begin
            abort_pend_q <= 1'b1;
            aborted_q    <= 1'b1;
          end
          if (str_done_i) begin
            pending_q             <= pending_clr_d;
            desc_done_q[str_id_q] <= 1'b1;
            rr_ptr_q              <= rr_next_d;
            if (str_err_i) begin
              desc_err_q[str_id_q] <= 1'b1;
              err_q                <= 1'b1;
              state_q              <= S_FIN;
            end else if (abort_pend_q || abort_i || (pending_clr_d == '0)) begin
              state_q <= S_FIN;
            end else begin
              state_q <= S_ARB;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign str_valid_o = str_valid_q;
  assign str_src_o   = str_src_q;
  assign str_dst_o   = str_dst_q;
  assign str_len_o   = str_len_q;
  assign str_id_o    = str_id_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign aborted_o   = aborted_q;
  assign desc_done_o = desc_done_q;
  assign desc_err_o  = desc_err_q;

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Bench for dma_desc_scheduler: directed runs plus randomized runs checked against
// a transaction-level model of round-robin issue order and final run status.
module tb_dma_desc_scheduler;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 32;

  logic clk = 1'b0;
  logic rst, go_i, abort_i, str_ready_i, str_done_i, str_err_i;
  logic [N-1:0]    desc_en_i;
  logic [N*AW-1:0] desc_src_i, desc_dst_i;
  logic [N*LW-1:0] desc_len_i;
  logic            str_valid_o, busy_o, done_o, err_o, aborted_o;
  logic [AW-1:0]   str_src_o, str_dst_o;
  logic [LW-1:0]   str_len_o;
  logic [0:0]      str_id_o;
  logic [N-1:0]    desc_done_o, desc_err_o;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] m_src [N];
  logic [AW-1:0] m_dst [N];
  logic [LW-1:0] m_len [N];
  logic [N-1:0]  m_en;
  int            m_rr = 0;

  dma_desc_scheduler #(.NUM_DESC(N), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .go_i(go_i), .abort_i(abort_i),
    .desc_en_i(desc_en_i), .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i),
    .desc_len_i(desc_len_i), .str_valid_o(str_valid_o), .str_ready_i(str_ready_i),
    .str_src_o(str_src_o), .str_dst_o(str_dst_o), .str_len_o(str_len_o),
    .str_id_o(str_id_o), .str_done_i(str_done_i), .str_err_i(str_err_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .aborted_o(aborted_o),
    .desc_done_o(desc_done_o), .desc_err_o(desc_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_desc();
    for (int k = 0; k < N; k++) begin
      desc_src_i[k*AW +: AW] = m_src[k];
      desc_dst_i[k*AW +: AW] = m_dst[k];
      desc_len_i[k*LW +: LW] = m_len[k];
    end
    desc_en_i = m_en;
  endtask

  task automatic set_desc(input logic [N-1:0] en, input logic [LW-1:0] l0, input logic [LW-1:0] l1);
    m_en = en;
    m_len[0] = l0;
    m_len[1] = l1;
    for (int k = 0; k < N; k++) begin
      m_src[k] = $urandom;
      m_dst[k] = $urandom;
    end
  endtask

  // One complete run; the streamer side is played here and every issue is
  // compared with the order the round-robin rules predict.
  task automatic run(input int err_slot, input int abort_at, input bit slow,
                     input bit arb_abort, input bit noise);
    int pend_list[$];
    int seq[$];
    logic [N-1:0] exp_done, exp_err;
    bit exp_aborted, exp_errf, stop, finished, abort_sent, cur_err;
    int s, exp_s, issued, cnt, cyc, done_cnt, done_cyc, vcycles;

    pend_list = {};
    seq = {};
    exp_done = '0;
    exp_err = '0;
    exp_errf = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = (m_rr + i) % N;
      if (m_en[s] && m_len[s] != 0) pend_list.push_back(s);
    end
    exp_aborted = arb_abort && (pend_list.size() > 0);
    if (!arb_abort) begin
      for (int i = 0; i < pend_list.size() && !stop; i++) begin
        s = pend_list[i];
        seq.push_back(s);
        exp_done[s] = 1'b1;
        if (i == abort_at) begin exp_aborted = 1'b1; stop = 1'b1; end
        if (s == err_slot) begin exp_err[s] = 1'b1; exp_errf = 1'b1; stop = 1'b1; end
      end
    end

    drive_desc();
    @(negedge clk);
    go_i = 1'b1;
    issued = 0; cnt = -1; cur_err = 1'b0; cyc = 0; finished = 1'b0;
    done_cnt = 0; done_cyc = -1; abort_sent = 1'b0; vcycles = 0;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      cyc++;
      go_i = noise && ($urandom_range(0, 3) == 0);
      abort_i = 1'b0; str_done_i = 1'b0; str_err_i = 1'b0;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1'b1;
        go_i = 1'b0;
        str_ready_i = 1'b0;
      end else begin
        if (arb_abort && cyc == 1) abort_i = 1'b1;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            str_done_i = 1'b1;
            str_err_i = cur_err;
            cnt = -1;
          end
        end else if (noise && $urandom_range(0, 3) == 0) begin
          str_done_i = 1'b1;
          str_err_i = 1'($urandom_range(0, 1));
        end
        if (str_valid_o) begin
          exp_s = (issued < seq.size()) ? seq[issued] : 99;
          check("str_id", str_id_o, exp_s);
          if (exp_s < N) begin
            check("str_src", str_src_o, m_src[exp_s]);
            check("str_dst", str_dst_o, m_dst[exp_s]);
            check("str_len", str_len_o, m_len[exp_s]);
            desc_src_i[exp_s*AW +: AW] = $urandom;
            desc_dst_i[exp_s*AW +: AW] = $urandom;
            desc_len_i[exp_s*LW +: LW] = $urandom;
          end
          vcycles++;
          if (abort_at == issued && !abort_sent) begin
            abort_i = 1'b1;
            abort_sent = 1'b1;
          end
          str_ready_i = slow ? (vcycles > 5) : 1'($urandom_range(0, 1));
          if (str_ready_i) begin
            if (slow) check("valid_hold", vcycles, 6);
            issued++;
            vcycles = 0;
            cnt = $urandom_range(1, 4);
            cur_err = (exp_s == err_slot);
          end
        end else begin
          str_ready_i = 1'($urandom_range(0, 1));
        end
      end
    end
    check("run_finished", finished, 1);
    check("issue_count", issued, seq.size());
    if (seq.size() == 0) check("done_latency", done_cyc, (pend_list.size() == 0) ? 2 : 3);
    check("busy_at_done", busy_o, 0);
    check("valid_at_done", str_valid_o, 0);
    check("desc_done", desc_done_o, exp_done);
    check("desc_err", desc_err_o, exp_err);
    check("err", err_o, exp_errf);
    check("aborted", aborted_o, exp_aborted);
    repeat (3) begin
      @(negedge clk);
      if (done_o) done_cnt++;
    end
    check("done_pulses", done_cnt, 1);
    check("desc_done_hold", desc_done_o, exp_done);
    if (seq.size() > 0) m_rr = (seq[seq.size()-1] + 1) % N;
  endtask

  initial begin
    int w;
    rst = 1'b1; go_i = 1'b0; abort_i = 1'b0; str_ready_i = 1'b0;
    str_done_i = 1'b0; str_err_i = 1'b0;
    desc_en_i = '0; desc_src_i = '0; desc_dst_i = '0; desc_len_i = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", str_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_aborted", aborted_o, 0);
    check("rst_desc_done", desc_done_o, 0);
    check("rst_desc_err", desc_err_o, 0);
    check("rst_id", str_id_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // two enabled slots, normal completion
    set_desc(2'b11, 64, 128);
    run(-1, -1, 1'b0, 1'b0, 1'b0);
    // fairness carries across runs
    set_desc(2'b01, 64, 128);
    run(-1, -1, 1'b0, 1'b0, 1'b0);
    set_desc(2'b11, 64, 128);
    run(-1, -1, 1'b0, 1'b0, 1'b0);

    // reset while waiting for the streamer
    set_desc(2'b11, 32, 48);
    drive_desc();
    @(negedge clk); go_i = 1'b1;
    @(negedge clk); go_i = 1'b0; str_ready_i = 1'b0;
    w = 0;
    while (!str_valid_o && w < 20) begin @(negedge clk); w++; end
    check("rst_wait_valid_seen", str_valid_o, 1);
    str_ready_i = 1'b1;
    @(negedge clk);
    str_ready_i = 1'b0;
    check("in_wait_busy", busy_o, 1);
    check("in_wait_valid", str_valid_o, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy_o, 0);
    check("midrst_valid", str_valid_o, 0);
    check("midrst_done", done_o, 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", done_o, 0);
    end
    m_rr = 0;
    run(-1, -1, 1'b0, 1'b0, 1'b0);

    // error on first slot skips the rest
    set_desc(2'b11, 16, 16);
    run(0, -1, 1'b0, 1'b0, 1'b0);
    // abort while offered with ready held low
    set_desc(2'b11, 100, 200);
    run(-1, 0, 1'b1, 1'b0, 1'b0);
    // enabled but empty slots
    set_desc(2'b11, 0, 0);
    run(-1, -1, 1'b0, 1'b0, 1'b0);
    // abort during arbitration
    set_desc(2'b11, 8, 8);
    run(-1, -1, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int e, a;
      set_desc(2'($urandom),
               ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 4096)),
               ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 4096)));
      e = $urandom_range(0, 3);
      a = $urandom_range(0, 3);
      run((e < N) ? e : -1, (a < N) ? a : -1, 1'b0, ($urandom_range(0, 9) == 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
